class_hash_mp: RTL and testbench
================================

Name: class_hash_mp

Overview:
- Parametrised multi-port classifier hash engine; next generation of the fixed two-port, fixed three-beat key hasher.
- Each of NUM_PORTS independent channels accepts a key of 1..KEY_BEATS beats over a valid/ready handshake.
- Short keys are zero-padded internally to KEY_BEATS beats.
- Each channel returns H1(k) (CRC-32 low bits) and H2(k) (CRC-16 low bits) through a backpressured output register, plus error flagging and counting.

Parameters:
- NUM_PORTS, 2, number of independent hash channels (1..8).
- BUS_WIDTH, 128, key beat width in bits.
- KEY_BEATS, 3, canonical key length in beats (1..15); shorter keys are zero-padded to this length.
- HASH_WIDTH, 13, bits of each hash output (1..16).
- ERR_CNT_WIDTH, 8, width of each per-port saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- key_vld  in  NUM_PORTS  per-port key beat valid.
- key_sop  in  NUM_PORTS  first beat of a key.
- key_eop  in  NUM_PORTS  last beat of a key.
- key_data  in  NUM_PORTS*BUS_WIDTH  key beats; port p occupies bits [p*BUS_WIDTH +: BUS_WIDTH].
- key_rdy  out  NUM_PORTS  per-port beat accept.
- hash_vld  out  NUM_PORTS  hash result valid.
- hash_rdy  in  NUM_PORTS  consumer accept.
- h1k  out  NUM_PORTS*HASH_WIDTH  CRC-32 derived hash.
- h2k  out  NUM_PORTS*HASH_WIDTH  CRC-16 derived hash.
- hash_err  out  NUM_PORTS  result belongs to a malformed key.
- err_cnt  out  NUM_PORTS*ERR_CNT_WIDTH  saturating malformed-key count.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all channels enter IDLE; key_rdy=all 1s; hash_vld, hash_err, h1k, h2k, err_cnt = 0.
- Reset mid-key or mid-output discards the key/result with no output.
- Beat transfer: a beat transfers when key_vld&key_rdy. A result transfers when hash_vld&hash_rdy.
- CRC-32: poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected, no final XOR.
- CRC-16: poly 0x1021, init 0xFFFF, non-reflected, no final XOR.
- CRC bit order: each beat is processed MSB (bit BUS_WIDTH-1) first. Both CRCs advance one full beat per cycle.
- Outputs: h1k = crc32[HASH_WIDTH-1:0]; h2k = crc16[HASH_WIDTH-1:0]. Both are registered and held stable while hash_vld=1.
- Per-port FSM:
  - IDLE: key_rdy=1. A beat with sop loads CRCs from the init value stepped by the data and sets beat_cnt=1, then goes to:
    - OUT if eop and KEY_BEATS=1;
    - PAD if eop and KEY_BEATS>1;
    - ACC otherwise.
  - IDLE, beat without sop: dropped; error counted; stay IDLE.
  - ACC: key_rdy=1. A beat without sop steps the CRCs and increments beat_cnt. Then:
    - eop -> PAD if beat_cnt<KEY_BEATS, else OUT;
    - beat_cnt reaching KEY_BEATS without eop -> OUT with hash_err=1, then DROP.
  - ACC, beat with sop: abort the current key, count an error, restart as an IDLE sop beat. No output for the aborted key.
  - PAD: key_rdy=0. Steps the CRCs with one all-zero beat per cycle until beat_cnt=KEY_BEATS, then OUT.
  - OUT: key_rdy=0; hash_vld=1. On hash_rdy, go to IDLE, or to DROP if the overlong flag is set.
  - DROP: key_rdy=1. Beats are discarded until a beat with eop, then IDLE.
  - DROP, beat with sop: treated as a new key start, same as IDLE.
- Latency:
  - A full-length key whose last beat transfers in cycle N has hash_vld=1 in cycle N+1.
  - A key of L<KEY_BEATS beats has hash_vld=1 in cycle N+1+(KEY_BEATS-L).
  - A result is the same as the zero-padded full-length key.
- Throughput: max one key per KEY_BEATS+1 cycles per port when hash_rdy is held high.
- Error counting:
  - err_cnt increments once per malformed event (orphan beat, sop abort, overlong key) and saturates at all 1s.
  - hash_err clears when the result is consumed.
- Independence: channels share no state. Simultaneous activity on all ports is fully parallel.

Test Plan:
- Full-length key, port 0: NUM_PORTS=2, KEY_BEATS=3, three beats 128'h0 (sop on beat 1, eop on beat 3), hash_rdy=1 -> hash_vld one cycle after beat 3; h1k/h2k equal the golden CRC-32/CRC-16 of 384 zero bits, masked to 13 bits; hash_err=0.
- Short-key padding: one beat 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 with sop&eop -> key_rdy low 2 cycles, hash_vld on cycle 3; hashes equal the 3-beat key {that beat, 0, 0}.
- Backpressure: hash_rdy=0 for 10 cycles after hash_vld -> h1k/h2k stable, key_rdy=0 throughout; a new key is accepted the cycle after hash_rdy=1.
- Malformed keys: sop mid-key -> err_cnt=1, only the second key is hashed. Then a 4-beat key -> result with hash_err=1 after beat 3, beat 4 dropped, err_cnt=2. Force 300 errors -> err_cnt=255.
- Parallel ports and reset: different keys on ports 0 and 1 in the same cycles -> independent correct hashes in the same cycle. Assert rst_n low mid-key -> outputs 0 immediately (asynchronously); after release the next key hashes correctly.

Source files
------------

// File: rtl/class_hash_mp.sv
// class_hash_mp: multi-port classifier hash engine.
// Each port hashes a 1..KEY_BEATS beat key (zero-padded to KEY_BEATS beats)
// into CRC-32/CRC-16 derived hashes, with malformed-key flagging and counting.

module class_hash_lane #(
  parameter int BUS_WIDTH     = 128,
  parameter int KEY_BEATS     = 3,
  parameter int HASH_WIDTH    = 13,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_vld,
  input  logic                     key_sop,
  input  logic                     key_eop,
  input  logic [BUS_WIDTH-1:0]     key_data,
  output logic                     key_rdy,
  output logic                     hash_vld,
  input  logic                     hash_rdy,
  output logic [HASH_WIDTH-1:0]    h1k,
  output logic [HASH_WIDTH-1:0]    h2k,
  output logic                     hash_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
  localparam int CW = $clog2(KEY_BEATS + 1);
  localparam logic [CW-1:0] KB = CW'(KEY_BEATS);

  typedef enum logic [2:0] {IDLE, ACC, PAD, OUT, DROP} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx, cnt_new;
  logic [31:0]            crc32, c32_base, c32_step;
  logic [15:0]            crc16, c16_base, c16_step;
  logic [BUS_WIDTH-1:0]   beat_d;
  logic                   start, step, load_out, overlong;
  logic [1:0]             err_add;
  logic [ERR_CNT_WIDTH:0] err_sum;

  // One full beat of CRC, MSB of the beat first.
  function automatic logic [31:0] crc32_beat(input logic [31:0] c, input logic [BUS_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = BUS_WIDTH - 1; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C1_1DB7 : 32'h0);
    return r;
  endfunction

  function automatic logic [15:0] crc16_beat(input logic [15:0] c, input logic [BUS_WIDTH-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = BUS_WIDTH - 1; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0);
    return r;
  endfunction

  assign key_rdy  = (state == IDLE) || (state == ACC) || (state == DROP);
  assign hash_vld = (state == OUT);

  // Next-state: a sop beat restarts the CRCs from init (start), a
  // continuation or pad beat advances them (step); both share one outcome path.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start    = 1'b0;
    step     = 1'b0;
    load_out = 1'b0;
    overlong = 1'b0;
    err_add  = 2'd0;
    beat_d   = key_data;
    case (state)
      IDLE: if (key_vld) begin
        if (key_sop) start = 1'b1;
        else         err_add = 2'd1;       // orphan beat
      end
      ACC: if (key_vld) begin
        if (key_sop) begin start = 1'b1; err_add = 2'd1; end  // abort + restart
        else         step = 1'b1;
      end
      PAD: begin
        beat_d = '0;
        step   = 1'b1;
      end
      OUT: if (hash_rdy) state_nx = hash_err ? DROP : IDLE;
      DROP: if (key_vld) begin
        if (key_sop)      start = 1'b1;
        else if (key_eop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    c32_base = start ? 32'hFFFF_FFFF : crc32;
    c16_base = start ? 16'hFFFF : crc16;
    cnt_new  = start ? CW'(1) : cnt + CW'(1);

    if (start || step) begin
      cnt_nx = cnt_new;
      if (state == PAD) begin
        if (cnt_new == KB) begin state_nx = OUT; load_out = 1'b1; end
      end else if (key_eop) begin
        if (cnt_new < KB) state_nx = PAD;
        else begin state_nx = OUT; load_out = 1'b1; end
      end else if (cnt_new >= KB) begin
        // key ran past KEY_BEATS: emit flagged result, then drop the tail
        state_nx = OUT;
        load_out = 1'b1;
        overlong = 1'b1;
        err_add  = err_add + 2'd1;
      end else begin
        state_nx = ACC;
      end
    end
  end

  assign c32_step = crc32_beat(c32_base, beat_d);
  assign c16_step = crc16_beat(c16_base, beat_d);
  assign err_sum  = {1'b0, err_cnt} + (ERR_CNT_WIDTH + 1)'(err_add);

  // State, CRC accumulators, result register and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      crc32    <= '0;
      crc16    <= '0;
      h1k      <= '0;
      h2k      <= '0;
      hash_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start || step) begin
        crc32 <= c32_step;
        crc16 <= c16_step;
      end
      if (load_out) begin
        h1k      <= c32_step[HASH_WIDTH-1:0];
        h2k      <= c16_step[HASH_WIDTH-1:0];
        hash_err <= overlong;
      end else if (state == OUT && hash_rdy) begin
        hash_err <= 1'b0;
      end
      err_cnt <= err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
    end
  end
endmodule

module class_hash_mp #(
  parameter int NUM_PORTS     = 2,
  parameter int BUS_WIDTH     = 128,
  parameter int KEY_BEATS     = 3,
  parameter int HASH_WIDTH    = 13,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS-1:0]               key_vld,
  input  logic [NUM_PORTS-1:0]               key_sop,
  input  logic [NUM_PORTS-1:0]               key_eop,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]     key_data,
  output logic [NUM_PORTS-1:0]               key_rdy,
  output logic [NUM_PORTS-1:0]               hash_vld,
  input  logic [NUM_PORTS-1:0]               hash_rdy,
  output logic [NUM_PORTS*HASH_WIDTH-1:0]    h1k,
  output logic [NUM_PORTS*HASH_WIDTH-1:0]    h2k,
  output logic [NUM_PORTS-1:0]               hash_err,
  output logic [NUM_PORTS*ERR_CNT_WIDTH-1:0] err_cnt
);
  // Fully independent channels, one lane per port.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    class_hash_lane #(
      .BUS_WIDTH    (BUS_WIDTH),
      .KEY_BEATS    (KEY_BEATS),
      .HASH_WIDTH   (HASH_WIDTH),
      .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_vld (key_vld[p]),
      .key_sop (key_sop[p]),
      .key_eop (key_eop[p]),
      .key_data(key_data[p*BUS_WIDTH +: BUS_WIDTH]),
      .key_rdy (key_rdy[p]),
      .hash_vld(hash_vld[p]),
      .hash_rdy(hash_rdy[p]),
      .h1k     (h1k[p*HASH_WIDTH +: HASH_WIDTH]),
      .h2k     (h2k[p*HASH_WIDTH +: HASH_WIDTH]),
      .hash_err(hash_err[p]),
      .err_cnt (err_cnt[p*ERR_CNT_WIDTH +: ERR_CNT_WIDTH])
    );
  end
endmodule

// File: tb/tb_class_hash_mp.sv
// Directed bench for class_hash_mp (2 ports, 3 x 128-bit beats, 13-bit hashes).
module tb_class_hash_mp;
  localparam int NP = 2, BW = 128, KB = 3, HW = 13, EW = 8;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NP-1:0]     key_vld = '0, key_sop = '0, key_eop = '0, key_rdy, hash_vld, hash_rdy = '0, hash_err;
  logic [NP*BW-1:0]  key_data = '0;
  logic [NP*HW-1:0]  h1k, h2k;
  logic [NP*EW-1:0]  err_cnt;
  int nvec = 0, nmis = 0;

  class_hash_mp #(.NUM_PORTS(NP), .BUS_WIDTH(BW), .KEY_BEATS(KB), .HASH_WIDTH(HW), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .key_vld(key_vld), .key_sop(key_sop), .key_eop(key_eop),
    .key_data(key_data), .key_rdy(key_rdy), .hash_vld(hash_vld), .hash_rdy(hash_rdy),
    .h1k(h1k), .h2k(h2k), .hash_err(hash_err), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  // Reference CRCs over the whole padded key, first beat in the top bits.
  function automatic logic [31:0] ref_crc32(input logic [KB*BW-1:0] m);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = KB*BW - 1; i >= 0; i--) begin
      logic fb;
      fb = c[31] ^ m[i];
      c  = c << 1;
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return c;
  endfunction

  function automatic logic [15:0] ref_crc16(input logic [KB*BW-1:0] m);
    logic [15:0] c = 16'hFFFF;
    for (int i = KB*BW - 1; i >= 0; i--) begin
      logic fb;
      fb = c[15] ^ m[i];
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic s, input logic e, input logic [BW-1:0] d);
    key_vld[p] = v; key_sop[p] = s; key_eop[p] = e;
    key_data[p*BW +: BW] = d;
  endtask

  task automatic beat(input int p, input logic s, input logic e, input logic [BW-1:0] d);
    drive(p, 1'b1, s, e, d);
    tick();
    drive(p, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_hash(input string tag, input int p, input logic [KB*BW-1:0] m, input logic err);
    logic [31:0] c32;
    logic [15:0] c16;
    c32 = ref_crc32(m);
    c16 = ref_crc16(m);
    check({tag, ".vld"}, 32'(hash_vld[p]), 32'd1);
    check({tag, ".h1k"}, 32'(h1k[p*HW +: HW]), 32'(c32[HW-1:0]));
    check({tag, ".h2k"}, 32'(h2k[p*HW +: HW]), 32'(c16[HW-1:0]));
    check({tag, ".err"}, 32'(hash_err[p]), 32'(err));
  endtask

  localparam logic [BW-1:0] B  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [BW-1:0] Z  = '0;

  initial begin
    logic [HW-1:0] h1_hold, h2_hold;

    // reset state
    tick(); tick();
    check("rst.key_rdy", 32'(key_rdy), 32'h3);
    check("rst.hash_vld", 32'(hash_vld), 32'h0);
    check("rst.h1k", 32'(h1k), 32'h0);
    check("rst.h2k", 32'(h2k), 32'h0);
    check("rst.hash_err", 32'(hash_err), 32'h0);
    check("rst.err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // full-length all-zero key on port 0
    hash_rdy = 2'b11;
    beat(0, 1'b1, 1'b0, Z);
    beat(0, 1'b0, 1'b0, Z);
    check("full.no_early_vld", 32'(hash_vld[0]), 32'd0);
    beat(0, 1'b0, 1'b1, Z);
    chk_hash("full", 0, {Z, Z, Z}, 1'b0);
    tick();
    check("full.consumed", 32'(hash_vld[0]), 32'd0);

    // short key padding, with backpressure on the result
    hash_rdy[0] = 1'b0;
    beat(0, 1'b1, 1'b1, B);
    check("pad.rdy1", 32'(key_rdy[0]), 32'd0);
    check("pad.vld1", 32'(hash_vld[0]), 32'd0);
    tick();
    check("pad.rdy2", 32'(key_rdy[0]), 32'd0);
    check("pad.vld2", 32'(hash_vld[0]), 32'd0);
    tick();
    chk_hash("pad", 0, {B, Z, Z}, 1'b0);
    h1_hold = h1k[HW-1:0];
    h2_hold = h2k[HW-1:0];
    drive(0, 1'b1, 1'b1, 1'b1, 128'hC0DE);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp.h1k", 32'(h1k[HW-1:0]), 32'(h1_hold));
      check("bp.h2k", 32'(h2k[HW-1:0]), 32'(h2_hold));
      check("bp.rdy", 32'(key_rdy[0]), 32'd0);
      check("bp.vld", 32'(hash_vld[0]), 32'd1);
    end
    hash_rdy[0] = 1'b1;
    tick();
    check("bp.release_vld", 32'(hash_vld[0]), 32'd0);
    check("bp.release_rdy", 32'(key_rdy[0]), 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    check("bp.accepted", 32'(key_rdy[0]), 32'd0);
    tick(); tick();
    chk_hash("bp.next", 0, {128'hC0DE, Z, Z}, 1'b0);
    tick();

    // sop mid-key aborts the first key
    beat(0, 1'b1, 1'b0, 128'hDEAD);
    beat(0, 1'b1, 1'b0, 128'hE1);
    check("abort.err_cnt", 32'(err_cnt[EW-1:0]), 32'd1);
    beat(0, 1'b0, 1'b0, 128'hE2);
    beat(0, 1'b0, 1'b1, 128'hE3);
    chk_hash("abort", 0, {128'hE1, 128'hE2, 128'hE3}, 1'b0);
    tick();

    // overlong key: flagged result after beat 3, beat 4 dropped
    beat(0, 1'b1, 1'b0, 128'hF1);
    beat(0, 1'b0, 1'b0, 128'hF2);
    beat(0, 1'b0, 1'b0, 128'hF3);
    chk_hash("ovl", 0, {128'hF1, 128'hF2, 128'hF3}, 1'b1);
    check("ovl.err_cnt", 32'(err_cnt[EW-1:0]), 32'd2);
    tick();
    check("ovl.err_clr", 32'(hash_err[0]), 32'd0);
    check("ovl.drop_rdy", 32'(key_rdy[0]), 32'd1);
    beat(0, 1'b0, 1'b1, 128'hF4);
    tick();
    check("ovl.no_result", 32'(hash_vld[0]), 32'd0);
    check("ovl.err_cnt2", 32'(err_cnt[EW-1:0]), 32'd2);

    // orphan beats saturate the counter
    drive(0, 1'b1, 1'b0, 1'b0, 128'h5);
    repeat (300) tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    check("sat.err_cnt", 32'(err_cnt[EW-1:0]), 32'd255);
    check("sat.port1", 32'(err_cnt[2*EW-1:EW]), 32'd0);

    // both ports in parallel
    drive(0, 1'b1, 1'b1, 1'b0, 128'hA1);  drive(1, 1'b1, 1'b1, 1'b0, 128'hB1); tick();
    drive(0, 1'b1, 1'b0, 1'b0, 128'hA2);  drive(1, 1'b1, 1'b0, 1'b0, 128'hB2); tick();
    drive(0, 1'b1, 1'b0, 1'b1, 128'hA3);  drive(1, 1'b1, 1'b0, 1'b1, B);       tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0);       drive(1, 1'b0, 1'b0, 1'b0, '0);
    chk_hash("par.p0", 0, {128'hA1, 128'hA2, 128'hA3}, 1'b0);
    chk_hash("par.p1", 1, {128'hB1, 128'hB2, B}, 1'b0);
    tick();

    // asynchronous reset mid-key
    beat(1, 1'b1, 1'b0, 128'h77);
    rst_n = 1'b0;
    #1;
    check("arst.key_rdy", 32'(key_rdy), 32'h3);
    check("arst.hash_vld", 32'(hash_vld), 32'h0);
    check("arst.h1k", 32'(h1k), 32'h0);
    check("arst.err_cnt", 32'(err_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(1, 1'b1, 1'b0, 128'h11);
    beat(1, 1'b0, 1'b0, 128'h22);
    beat(1, 1'b0, 1'b1, 128'h33);
    chk_hash("arst.after", 1, {128'h11, 128'h22, 128'h33}, 1'b0);
    check("arst.p0_idle", 32'(hash_vld[0]), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
